// File: rtl/core_trace_monitor_pkg.sv
// core_trace_monitor_pkg: shared types and constants for the retired-instruction trace monitor.
// Contents: entry record, its width TRACE_W, the halt FSM state type and the halt instruction codes.
// TRACE_REGWRITE_EN: when defined, the entry record also carries {rd_we, rd_addr, rd_wdata}.
package core_trace_monitor_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] HALT_INSN_ZERO = 32'h0000_0000;
  localparam logic [31:0] JAL_SELF = 32'h0000_006f;
  typedef struct packed {
    logic we;
    logic [4:0] addr;
    logic [XLEN-1:0] data;
  } wb_t;
  typedef struct packed {
`ifdef TRACE_REGWRITE_EN
    wb_t wb;
`endif
    logic [XLEN-1:0] pc;
    logic [31:0] insn;
  } entry_t;
  localparam int TRACE_W = $bits(entry_t);
  typedef enum logic {ST_RUN, ST_HALTED} halt_state_t;
endpackage

// File: rtl/core_trace_monitor_if.sv
// core_trace_monitor_if: bundle of capture inputs, read port and status outputs of the trace monitor.
// master: drives enable/clear/retire/read-request, observes responses and status (core or bench side).
// slave: the monitor itself.
interface core_trace_monitor_if import core_trace_monitor_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 10
);
  localparam int AW = $clog2(DEPTH);
  logic enable;
  logic clear;
  logic retire_valid;
  logic [XLEN-1:0] pc;
  logic [31:0] instruction;
  logic rd_we;
  logic [4:0] rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic rd_req;
  logic [AW-1:0] rd_idx;
  logic rd_ack;
  logic rd_hit;
  logic [XLEN-1:0] rd_pc;
  logic [31:0] rd_insn;
  logic [XLEN+5:0] rd_wb;
  logic [AW:0] entries;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] retired;
  logic halted;
  modport master (
    output enable, clear, retire_valid, pc, instruction, rd_we, rd_addr, rd_wdata, rd_req, rd_idx,
    input rd_ack, rd_hit, rd_pc, rd_insn, rd_wb, entries, cycles, retired, halted
  );
  modport slave (
    input enable, clear, retire_valid, pc, instruction, rd_we, rd_addr, rd_wdata, rd_req, rd_idx,
    output rd_ack, rd_hit, rd_pc, rd_insn, rd_wb, entries, cycles, retired, halted
  );
endinterface

// File: rtl/core_trace_monitor_trace_ram.sv
// trace_ram: DEPTH x W storage, one write port, registered read port, storage not reset.
// Ports: clk; i_we/i_waddr/i_wdata write; i_re/i_raddr read request; o_rdata valid the next cycle.
// A read and write to the same slot in one cycle returns the old contents.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W = 64
) (
  input logic clk,
  input logic i_we,
  input logic [$clog2(DEPTH)-1:0] i_waddr,
  input logic [W-1:0] i_wdata,
  input logic i_re,
  input logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0] o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/core_trace_monitor.sv
// core_trace_monitor: circular trace of retired instructions, saturating cycle/retire counters,
// sticky halt detection and a 1-cycle-latency read port for the rv32i core.
// Ports: clk (rising edge), reset (async, active-low), bus (core_trace_monitor_if.slave).
// TRACE_REGWRITE_EN: when defined, entries also hold {rd_we, rd_addr, rd_wdata}, returned on rd_wb;
// otherwise that field is not stored and rd_wb is tied to 0.
module core_trace_monitor import core_trace_monitor_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 10,
  parameter int HALT_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  core_trace_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(HALT_CYCLES + 1);
  halt_state_t r_state, w_state_nx;
  logic [AW-1:0] r_wr_ptr, w_rd_slot;
  logic [AW:0] r_entries;
  logic [CNT_W-1:0] r_cycles, r_retired;
  logic [XLEN-1:0] r_last_pc;
  logic [RW-1:0] r_run, w_run_nx;
  logic r_ack, r_hit, w_active, w_wr, w_halt;
  entry_t w_wentry, w_rentry;
  assign w_active = bus.enable & (r_state == ST_RUN);
  assign w_wr = w_active & bus.retire_valid & ~bus.clear;
  // run of zero means no retire seen since reset/clear, so the first retire always starts at 1
  assign w_run_nx = (r_run != '0 && bus.pc == r_last_pc) ? r_run + 1'b1 : RW'(1);
  assign w_halt = w_wr & (bus.instruction == HALT_INSN_ZERO || w_run_nx == RW'(HALT_CYCLES));
  // oldest entry sits entries slots behind the write pointer; modulo DEPTH falls out of the AW-bit width
  assign w_rd_slot = r_wr_ptr - r_entries[AW-1:0] + bus.rd_idx;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = bus.clear ? ST_RUN : w_halt ? ST_HALTED : r_state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_wr_ptr <= '0;
      r_entries <= '0;
      r_cycles <= '0;
      r_retired <= '0;
      r_last_pc <= '0;
      r_run <= '0;
      r_ack <= 1'b0;
      r_hit <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ack <= bus.rd_req;
      r_hit <= bus.rd_req & ~bus.clear & ({1'b0, bus.rd_idx} < r_entries);
      if (bus.clear) begin
        r_wr_ptr <= '0;
        r_entries <= '0;
        r_cycles <= '0;
        r_retired <= '0;
        r_last_pc <= '0;
        r_run <= '0;
      end else begin
        if (w_active && !(&r_cycles)) r_cycles <= r_cycles + 1'b1;
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_last_pc <= bus.pc;
          r_run <= w_run_nx;
          if (!(&r_retired)) r_retired <= r_retired + 1'b1;
          if (r_entries != (AW+1)'(DEPTH)) r_entries <= r_entries + 1'b1;
        end
      end
    end
  end
`ifdef TRACE_REGWRITE_EN
  assign w_wentry = '{wb: '{we: bus.rd_we, addr: bus.rd_addr, data: bus.rd_wdata}, pc: bus.pc, insn: bus.instruction};
  assign bus.rd_wb = r_hit ? w_rentry.wb : '0;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{bus.rd_we, bus.rd_addr, bus.rd_wdata};
  assign w_wentry = '{pc: bus.pc, insn: bus.instruction};
  assign bus.rd_wb = '0;
`endif
  trace_ram #(.DEPTH(DEPTH), .W(TRACE_W)) u_ram (
    .clk(clk),
    .i_we(w_wr),
    .i_waddr(r_wr_ptr),
    .i_wdata(w_wentry),
    .i_re(bus.rd_req),
    .i_raddr(w_rd_slot),
    .o_rdata(w_rentry)
  );
  assign bus.rd_ack = r_ack;
  assign bus.rd_hit = r_hit;
  assign bus.rd_pc = r_hit ? w_rentry.pc : '0;
  assign bus.rd_insn = r_hit ? w_rentry.insn : '0;
  assign bus.entries = r_entries;
  assign bus.cycles = r_cycles;
  assign bus.retired = r_retired;
  assign bus.halted = (r_state == ST_HALTED);
endmodule
